// File: rtl/lsu_pkg.sv
// Purpose : shared types and constants for the load/store unit.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: access-size codes, FSM state encoding.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also handled as a word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Purpose : lane extraction (with sign/zero extension) and lane merge for sub-word accesses.
// Latency : purely combinational.
// Backpr. : none.
// Ports   : i_word  memory word, i_wdata store data (low bits used), i_lane byte lane,
//           i_size access size, i_uns zero-extend; o_ext extended load value, o_merge merged word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_ext,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        // Halfwords only look at lane[1]; lane[0] is ignored (forced aligned).
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_ext = i_word;
        case (i_size)
            SZ_BYTE: o_ext = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_ext = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_ext = i_word;
        endcase
    end

    always_comb begin
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_lane)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
                else           o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Purpose : load/store sequencer in front of a word-only data memory; sub-word stores use read-modify-write.
// Latency : load / word store done 2 cycles after accept, sub-word store 3; next request accepted the cycle after done.
// Backpr. : ready high only in IDLE; req while busy is dropped, not queued.
// Ports   : req/we/size/uns/addr/wdata request in; ready/done/rdata/exc status out;
//           dm_addr/dm_din/dm_wEn/dm_dout memory side (memory writes on negedge, reads combinationally).
// Option  : define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses on exc instead of aligning them.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DM_AW  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              exc,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_wEn,
    input  logic [31:0]       dm_dout
);

    lsu_state_e        r_state;
    logic              r_we_q;
    logic [1:0]        r_size_q;
    logic              r_uns_q;
    logic [DM_AW+1:0]  r_addr_q;
    logic [31:0]       r_wdata_q;
    logic [31:0]       r_merge_q;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_exc;
    logic [31:0]       r_din_last;

    logic [31:0]       w_ext;
    logic [31:0]       w_merge;
    logic              w_misalign;
    logic              w_word_wr;
    logic              w_wr_phase;
    logic [31:0]       w_dm_din;
    logic              w_unused_addr;

    // Address bits above the memory window never reach the memory.
    assign w_unused_addr = &{1'b0, addr[ADDR_W-1:DM_AW+2]};

`ifdef LSU_MISALIGN_EXC_EN
    assign w_misalign = ((r_size_q == SZ_HALF) && r_addr_q[0]) ||
                        (r_size_q[1] && (r_addr_q[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    lsu_byte_lane u_lane (
        .i_word  (dm_dout),
        .i_wdata (r_wdata_q),
        .i_lane  (r_addr_q[1:0]),
        .i_size  (r_size_q),
        .i_uns   (r_uns_q),
        .o_ext   (w_ext),
        .o_merge (w_merge)
    );

    assign w_word_wr  = (r_state == ACC) && r_we_q && r_size_q[1] && !w_misalign;
    assign w_wr_phase = w_word_wr || (r_state == WR);

    // Write data is muxed combinationally so it is valid at the negedge of the
    // write cycle; otherwise it holds whatever was last presented.
    assign w_dm_din = w_word_wr         ? r_wdata_q :
                      (r_state == WR)   ? r_merge_q : r_din_last;

    // rst_n gates the strobe directly so a reset asserted mid-write blocks the negedge write.
    assign dm_wEn  = w_wr_phase & rst_n;
    assign dm_din  = w_dm_din;
    assign dm_addr = r_addr_q[DM_AW+1:2];
    assign ready   = (r_state == IDLE);
    assign done    = r_done;
    assign rdata   = r_rdata;
    assign exc     = r_exc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we_q     <= 1'b0;
            r_size_q   <= 2'b00;
            r_uns_q    <= 1'b0;
            r_addr_q   <= '0;
            r_wdata_q  <= 32'h0;
            r_merge_q  <= 32'h0;
            r_rdata    <= 32'h0;
            r_done     <= 1'b0;
            r_exc      <= 1'b0;
            r_din_last <= 32'h0;
        end else begin
            r_done     <= 1'b0;
            r_exc      <= 1'b0;
            r_din_last <= w_dm_din;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we_q    <= we;
                        r_size_q  <= size;
                        r_uns_q   <= uns;
                        r_addr_q  <= addr[DM_AW+1:0];
                        r_wdata_q <= wdata;
                        r_state   <= ACC;
                    end
                end
                ACC: begin
                    if (w_misalign) begin
                        r_exc   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (!r_we_q) begin
                        r_rdata <= w_ext;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_size_q[1]) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_merge_q <= w_merge;
                        r_state   <= WR;
                    end
                end
                WR: begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, exc, dm_wEn;
    logic [31:0] rdata, dm_din, dm_dout;
    logic [9:0]  dm_addr;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_rdata = 32'h0;
    int          wen_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DM_AW(10)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
        .exc(exc), .dm_addr(dm_addr), .dm_din(dm_din), .dm_wEn(dm_wEn), .dm_dout(dm_dout)
    );

    // Word-only memory: combinational read, negedge write.
    assign dm_dout = mem[dm_addr];
    always @(negedge clk) begin
        if (dm_wEn) begin
            mem[dm_addr] = dm_din;
            wen_cnt = wen_cnt + 1;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model operates on byte addresses with plain shifts and masks.
    function automatic logic ref_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_EXC_EN
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return 1'b0 & sz[0] & a[0];
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
        logic [31:0] w, v;
        w = ref_mem[a[11:2]];
        if (sz == 2'b00) begin
            v = (w >> (int'(a[1:0]) * 8)) & 32'h0000_00FF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (int'(a[1]) * 16)) & 32'h0000_FFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask, dat;
        int sh;
        if (sz == 2'b00) begin
            sh = int'(a[1:0]) * 8;
            mask = 32'h0000_00FF << sh;
            dat  = (d & 32'h0000_00FF) << sh;
        end else if (sz == 2'b01) begin
            sh = int'(a[1]) * 16;
            mask = 32'h0000_FFFF << sh;
            dat  = (d & 32'h0000_FFFF) << sh;
        end else begin
            mask = 32'hFFFF_FFFF;
            dat  = d;
        end
        ref_mem[a[11:2]] = (ref_mem[a[11:2]] & ~mask) | dat;
    endtask

    task automatic do_op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        logic mis, exc_d;
        int   exp_lat, exp_wen, w0, done_cyc, idx;
        idx = int'(a[11:2]);
        mis = ref_misalign(sz, a);
        exp_lat = (w && !sz[1] && !mis) ? 3 : 2;
        exp_wen = (w && !mis) ? 1 : 0;
        if (!w && !mis) ref_rdata = ref_load(sz, u, a);
        if (w && !mis) ref_store(sz, a, d);

        @(negedge clk);
        check32($sformatf("%s.ready", tag), {31'b0, ready}, 32'd1);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        w0 = wen_cnt;
        done_cyc = 0;
        exc_d = 1'b0;
        for (int c = 1; c <= 6 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                exc_d = exc;
            end
        end
        check32($sformatf("%s.latency", tag), done_cyc, exp_lat);
        check32($sformatf("%s.exc", tag), {31'b0, exc_d}, {31'b0, mis});
        @(negedge clk);
        #1;
        check32($sformatf("%s.done_pulse", tag), {31'b0, done}, 32'd0);
        check32($sformatf("%s.ready_after", tag), {31'b0, ready}, 32'd1);
        check32($sformatf("%s.rdata", tag), rdata, ref_rdata);
        check32($sformatf("%s.wen", tag), wen_cnt - w0, exp_wen);
        check32($sformatf("%s.mem", tag), mem[idx], ref_mem[idx]);
    endtask

    initial begin
        int ndone, first, w0;
        logic [31:0] v, m5;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check32("rst.ready", {31'b0, ready}, 32'd1);
        check32("rst.done", {31'b0, done}, 32'd0);
        check32("rst.rdata", rdata, 32'h0);
        check32("rst.exc", {31'b0, exc}, 32'd0);
        check32("rst.dm_din", dm_din, 32'h0);
        check32("rst.dm_wEn", {31'b0, dm_wEn}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load
        do_op("sw_dead", 1'b1, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF);
        check32("sw_dead.dm4", mem[4], 32'hDEADBEEF);
        do_op("lw_dead", 1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0);
        check32("lw_dead.val", rdata, 32'hDEADBEEF);

        // Byte loads
        do_op("sw_pat", 1'b1, SZ_WORD, 1'b0, 32'h010, 32'h8081_7F01);
        do_op("lb13", 1'b0, SZ_BYTE, 1'b0, 32'h013, 32'h0);
        check32("lb13.val", rdata, 32'hFFFF_FF80);
        do_op("lbu13", 1'b0, SZ_BYTE, 1'b1, 32'h013, 32'h0);
        check32("lbu13.val", rdata, 32'h0000_0080);
        do_op("lb11", 1'b0, SZ_BYTE, 1'b0, 32'h011, 32'h0);
        check32("lb11.val", rdata, 32'h0000_007F);

        // Sub-word stores (read-modify-write)
        do_op("sw5", 1'b1, SZ_WORD, 1'b0, 32'h014, 32'h1122_3344);
        do_op("sb16", 1'b1, SZ_BYTE, 1'b0, 32'h016, 32'h1234_56AA);
        check32("sb16.val", mem[5], 32'h11AA_3344);
        do_op("sh14", 1'b1, SZ_HALF, 1'b0, 32'h014, 32'h9876_BEEF);
        check32("sh14.val", mem[5], 32'h11AA_BEEF);

        // Misaligned word store
        do_op("sw21", 1'b1, SZ_WORD, 1'b0, 32'h021, 32'h1234_5678);
`ifndef LSU_MISALIGN_EXC_EN
        check32("sw21.dm8", mem[8], 32'h1234_5678);
`endif

        // Back-to-back: req held high, four word stores fit in 12 cycles
        ndone = 0; first = 0; w0 = wen_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SZ_WORD; uns = 1'b0; addr = 32'h040; wdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        req = 1'b0;
        ref_mem[16] = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        check32("b2b.ndone", ndone, 4);
        check32("b2b.first", first, 2);
        check32("b2b.wen", wen_cnt - w0, 4);
        check32("b2b.mem", mem[16], ref_mem[16]);

        // Reset asserted during the write phase of a byte store
        do_op("lw_pre", 1'b0, SZ_WORD, 1'b0, 32'h014, 32'h0);
        m5 = mem[5];
        w0 = wen_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SZ_BYTE; uns = 1'b0; addr = 32'h016; wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_rdata = 32'h0;
        @(negedge clk);
        #1;
        check32("mrst.ready", {31'b0, ready}, 32'd1);
        check32("mrst.rdata", rdata, 32'h0);
        check32("mrst.done", {31'b0, done}, 32'd0);
        check32("mrst.dm_din", dm_din, 32'h0);
        check32("mrst.mem", mem[5], m5);
        check32("mrst.wen", wen_cnt - w0, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
